imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
Writer side of the instruction memory. The block receives a byte stream through a valid/ready handshake, for example from a UART receiver or debug bridge. It assembles the bytes little-endian into WIDTH-bit instruction words and drives a one-cycle write port into a writable instruction memory at consecutive word addresses starting at 0. The CPU is held in reset (cpu_hold) until the programmed number of words has been written. This replaces load-time file initialisation of the memory.

Parameters:
WIDTH, 32, instruction word width; must be a multiple of 8
DEPTH, 256, memory depth in words
ADDR_W, $clog2(DEPTH), word-address width
BYTES, WIDTH/8, bytes per word

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  single-cycle pulse; begins a load when idle or done
word_count  input  ADDR_W+1  number of words to load; sampled on accepted start
s_data  input  8  incoming byte
s_valid  input  1  s_data valid
s_ready  output  1  loader accepts a byte this cycle
we  output  1  memory write enable, one-cycle pulse per word
waddr  output  ADDR_W  word address of the write
wdata  output  WIDTH  assembled word
busy  output  1  load in progress
done  output  1  load complete; held until the next accepted start or reset
err  output  1  word_count exceeded DEPTH; held until the next accepted start or reset
cpu_hold  output  1  keep the CPU in reset while high

Behaviour:
- Reset (asynchronous, any state, including mid-word or mid-load):
  - state=IDLE.
  - byte_idx=0, word_idx=0, shift register=0.
  - s_ready=0, we=0, waddr=0, wdata=0, busy=0, done=0, err=0, cpu_hold=1.
  - A partial word is discarded; memory already written is not cleared.
- States: IDLE, RECV, WRITE, DONE.
- IDLE: cpu_hold=1, s_ready=0.
  - start=1: latch count = min(word_count, DEPTH).
  - err=1 if word_count > DEPTH, otherwise 0.
  - count==0 → DONE; otherwise → RECV with byte_idx=0, word_idx=0.
- RECV: busy=1, s_ready=1.
  - A byte is accepted when s_valid && s_ready.
  - The accepted byte goes to lane byte_idx (bits 8*byte_idx+7 : 8*byte_idx); the first byte is the LSB.
  - byte_idx increments on each accepted byte.
  - On the BYTES-th accepted byte → WRITE and reset byte_idx to 0.
  - s_valid=0 stalls indefinitely; there is no timeout.
- WRITE (exactly one cycle): busy=1, s_ready=0, we=1, waddr=word_idx, wdata=assembled word.
  - Then word_idx increments.
  - If word_idx was count-1 → DONE; otherwise → RECV.
- DONE: busy=0, done=1, cpu_hold=0, s_ready=0.
  - Bytes arriving here are not accepted (left pending on the source).
  - start=1 → behaves as in IDLE: reload count, clear done, raise cpu_hold.
- Timing:
  - we is asserted in the cycle after the last byte of a word is accepted.
  - Peak throughput is BYTES+1 cycles per word.
  - done and cpu_hold=0 take effect in the cycle after the final we.
- start asserted in RECV or WRITE is ignored.
- word_count==DEPTH writes addresses 0..DEPTH-1. word_idx never wraps because the count is clamped.
- waddr and wdata hold their last values outside WRITE; only we qualifies them.
- All outputs are registered.

Decomposition:
- Shared package (imem_pkg): loader_state_t enum {IDLE, RECV, WRITE, DONE}, plus the WIDTH/DEPTH defaults and the ADDR_W derivation, so the memory and the loader agree.
- Optional sub-module byte_packer: shift register plus byte counter; emits word_valid after BYTES accepted bytes, with a clear input.
- The FSM and the address counter stay in imem_loader.

Test Plan:
1. Reset, start with word_count=2, stream bytes 13 00 00 00 93 00 10 00.
   - Required: we pulses twice, waddr=0 wdata=0x00000013, then waddr=1 wdata=0x00100093.
   - done=1 and cpu_hold=0 in the cycle after the second we.
2. Backpressure: s_valid toggles 1,0,0,1,... for one word.
   - Only bytes with s_valid && s_ready are captured.
   - wdata equals the four accepted bytes in order; no duplicates.
3. start with word_count=0 → DONE in the next cycle.
   - we never asserts, done=1, err=0.
4. word_count=300 with DEPTH=256 → err=1.
   - Exactly 256 writes to addresses 0..255, then done=1.
5. Assert reset after 2 bytes of word 1 during a word_count=3 load.
   - All outputs return to reset values immediately; cpu_hold=1.
   - A new start with count=1 writes waddr=0 with only the new bytes.
6. start pulse during RECV is ignored.
   - A start pulse in DONE restarts the load: done→0, cpu_hold→1, waddr restarts at 0.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction memory and its byte-stream loader.
package imem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } loader_state_t;

    localparam int IMEM_WIDTH  = 32;
    localparam int IMEM_DEPTH  = 256;
    localparam int IMEM_ADDR_W = $clog2(IMEM_DEPTH);

endpackage

// File: rtl/byte_packer.sv
// Little-endian byte-to-word assembler: bytes shift in from the top, so the
// first accepted byte ends up in the least significant lane.
module byte_packer #(
    parameter int WIDTH = 32,
    parameter int BYTES = WIDTH / 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             word_valid,
    output logic [WIDTH-1:0] word_next
);

    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] sr_q, sr_d;

    // word_next is the word as it will look once the current byte lands
    generate
        if (BYTES > 1) begin : g_shift
            assign word_next = {in_data, sr_q[WIDTH-1:8]};
        end else begin : g_single
            assign word_next = in_data;
        end
    endgenerate

    assign word_valid = in_valid && (idx_q == LAST_IDX);

    always_comb begin
        idx_d = idx_q;
        sr_d  = sr_q;
        if (clr) begin
            idx_d = '0;
            sr_d  = '0;
        end else if (in_valid) begin
            sr_d  = word_next;
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q <= '0;
            sr_q  <= '0;
        end else begin
            idx_q <= idx_d;
            sr_q  <= sr_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Streams bytes into consecutive instruction-memory words and holds the CPU
// in reset until the requested number of words has been written.
module imem_loader
    import imem_pkg::*;
#(
    parameter int WIDTH  = IMEM_WIDTH,
    parameter int DEPTH  = IMEM_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int BYTES  = WIDTH / 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [WIDTH-1:0]  wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cpu_hold
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    loader_state_t     state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W:0]   word_idx_q, word_idx_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [WIDTH-1:0]  wdata_q, wdata_d;
    logic              err_q, err_d;
    logic              s_ready_q, we_q, busy_q, done_q, cpu_hold_q;

    logic              accept;
    logic              pack_clr;
    logic              word_valid;
    logic [WIDTH-1:0]  word_next;
    logic [ADDR_W:0]   start_count;

    assign accept      = s_valid && s_ready_q;
    assign start_count = (word_count > DEPTH_C) ? DEPTH_C : word_count;

    byte_packer #(
        .WIDTH (WIDTH),
        .BYTES (BYTES)
    ) u_packer (
        .clk        (clk),
        .reset      (reset),
        .clr        (pack_clr),
        .in_valid   (accept),
        .in_data    (s_data),
        .word_valid (word_valid),
        .word_next  (word_next)
    );

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        word_idx_d = word_idx_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        pack_clr   = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    count_d    = start_count;
                    err_d      = (word_count > DEPTH_C);
                    word_idx_d = '0;
                    pack_clr   = 1'b1;
                    state_d    = (start_count == '0) ? DONE : RECV;
                end
            end
            RECV: begin
                if (word_valid) begin
                    waddr_d = word_idx_q[ADDR_W-1:0];
                    wdata_d = word_next;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                word_idx_d = word_idx_q + 1'b1;
                state_d    = (word_idx_q == count_q - 1'b1) ? DONE : RECV;
            end
            default: state_d = IDLE;
        endcase
    end

    // Status outputs are registered off the next state so they line up with it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            word_idx_q <= '0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
            s_ready_q  <= 1'b0;
            we_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cpu_hold_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            word_idx_q <= word_idx_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
            s_ready_q  <= (state_d == RECV);
            we_q       <= (state_d == WRITE);
            busy_q     <= (state_d == RECV) || (state_d == WRITE);
            done_q     <= (state_d == DONE);
            cpu_hold_q <= (state_d != DONE);
        end
    end

    assign s_ready  = s_ready_q;
    assign we       = we_q;
    assign waddr    = waddr_q;
    assign wdata    = wdata_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign cpu_hold = cpu_hold_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: table of single-word loads plus
// hand-written sequences for reset, clamping and restart corner cases.
module tb_imem_loader;

    localparam int WIDTH  = 32;
    localparam int DEPTH  = 256;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W:0]   word_count;
    logic [7:0]        s_data;
    logic              s_valid;
    logic              s_ready;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [WIDTH-1:0]  wdata;
    logic              busy, done, err, cpu_hold;

    int checks = 0;
    int errors = 0;
    int wr_total = 0;

    imem_loader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .word_count (word_count),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .cpu_hold   (cpu_hold)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (we === 1'b1) wr_total++;

    typedef struct {
        logic [7:0]  b [4];
        int          g [4];
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        s_valid = 1'b0;
        s_data  = 8'hAA;
        repeat (gap) tick();
        s_valid = 1'b1;
        s_data  = b;
        n = 0;
        while (s_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL send_byte_timeout actual=no_ready expected=ready");
        end else begin
            tick();
        end
        s_valid = 1'b0;
        s_data  = 8'hAA;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 0);
    endtask

    task automatic do_start(input int cnt);
        start      = 1'b1;
        word_count = (ADDR_W + 1)'(cnt);
        tick();
        start      = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        int base;
        int bad;

        vecs[0] = '{'{8'hEF, 8'hBE, 8'hAD, 8'hDE}, '{0, 0, 0, 0}, 32'hDEADBEEF};
        vecs[1] = '{'{8'h01, 8'h02, 8'h03, 8'h04}, '{0, 2, 2, 2}, 32'h04030201};
        vecs[2] = '{'{8'hB7, 8'h02, 8'h00, 8'h80}, '{1, 1, 1, 1}, 32'h800002B7};
        vecs[3] = '{'{8'hFF, 8'h00, 8'hFF, 8'h00}, '{3, 0, 3, 0}, 32'h00FF00FF};

        reset = 1'b1; start = 1'b0; word_count = '0; s_data = 8'hAA; s_valid = 1'b0;
        tick();
        chk("rst_s_ready", s_ready, 0);
        chk("rst_we", we, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_busy_done_err", {busy, done, err}, 0);
        chk("rst_cpu_hold", cpu_hold, 1);
        reset = 1'b0;
        tick();

        // Basic two-word load
        do_start(2);
        chk("t1_busy_ready", {busy, s_ready}, 2'b11);
        base = wr_total;
        send_byte(8'h13, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        chk("t1_w0_we", we, 1);
        chk("t1_w0_addr", waddr, 0);
        chk("t1_w0_data", wdata, 32'h00000013);
        chk("t1_w0_ready_low", s_ready, 0);
        send_byte(8'h93, 0); send_byte(8'h00, 0); send_byte(8'h10, 0); send_byte(8'h00, 0);
        chk("t1_w1_we", we, 1);
        chk("t1_w1_addr", waddr, 1);
        chk("t1_w1_data", wdata, 32'h00100093);
        chk("t1_w1_not_done_yet", done, 0);
        tick();
        chk("t1_done_hold", {done, cpu_hold, busy, we}, 4'b1000);
        chk("t1_writes", wr_total - base, 2);

        // Table of single-word loads with various stall patterns
        foreach (vecs[i]) begin
            do_start(1);
            base = wr_total;
            for (int k = 0; k < 4; k++) send_byte(vecs[i].b[k], vecs[i].g[k]);
            chk($sformatf("vec%0d_we", i), we, 1);
            chk($sformatf("vec%0d_addr", i), waddr, 0);
            chk($sformatf("vec%0d_data", i), wdata, vecs[i].exp);
            tick();
            chk($sformatf("vec%0d_done", i), {done, cpu_hold}, 2'b10);
            chk($sformatf("vec%0d_writes", i), wr_total - base, 1);
        end

        // Zero-word load goes straight to DONE
        do_reset();
        base = wr_total;
        do_start(0);
        chk("t3_done", {done, cpu_hold, err, busy}, 4'b1000);
        repeat (3) tick();
        chk("t3_no_writes", wr_total - base, 0);

        // Oversized count clamps to DEPTH and flags err
        do_start(300);
        chk("t4_err", err, 1);
        base = wr_total;
        bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            send_word(32'(i) * 32'h01010101);
            if (we !== 1'b1 || waddr !== ADDR_W'(i)) bad++;
        end
        chk("t4_addr_seq", bad, 0);
        chk("t4_last_data", wdata, 32'hFFFFFFFF);
        tick();
        chk("t4_done_err", {done, err, cpu_hold}, 3'b110);
        s_valid = 1'b1; s_data = 8'h55;
        bad = 0;
        repeat (3) begin
            tick();
            if (s_ready !== 1'b0) bad++;
        end
        s_valid = 1'b0;
        chk("t4_no_accept_in_done", bad, 0);
        chk("t4_writes", wr_total - base, DEPTH);

        // Reset in the middle of a word
        do_start(3);
        chk("t5_err_cleared", err, 0);
        send_word(32'h12345678);
        send_byte(8'hC3, 0); send_byte(8'h3C, 0);
        reset = 1'b1;
        #1;
        chk("t5_rst_outs", {s_ready, we, busy, done, err, cpu_hold}, 6'b000001);
        chk("t5_rst_addr_data", {waddr, wdata}, 0);
        tick();
        reset = 1'b0;
        tick();
        do_start(1);
        send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
        chk("t5_new_addr", waddr, 0);
        chk("t5_new_data", wdata, 32'h44332211);

        // start in RECV is ignored; start in DONE restarts
        tick();
        do_start(2);
        send_byte(8'hA1, 0);
        do_start(1);
        chk("t6_still_busy", {busy, s_ready}, 2'b11);
        send_byte(8'hA2, 0); send_byte(8'hA3, 0); send_byte(8'hA4, 0);
        chk("t6_w0_data", wdata, 32'hA4A3A2A1);
        tick();
        chk("t6_not_done_after_one", done, 0);
        send_word(32'hCAFEF00D);
        chk("t6_w1_addr", waddr, 1);
        tick();
        chk("t6_done", done, 1);
        do_start(1);
        chk("t6_restart", {done, cpu_hold, busy}, 3'b011);
        send_word(32'h0BADC0DE);
        chk("t6_restart_addr", waddr, 0);
        chk("t6_restart_data", wdata, 32'h0BADC0DE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
